multi_digit_display_driver: RTL
===============================

MULTI_DIGIT_DISPLAY_DRIVER -- requirements
Module: multi_digit_display_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is driven per scan slot; legal minimum 2.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 load  in  1  single-cycle strobe; captures value, dp_in, hex_mode and lz_blank into the shadow register.
REQ-007 value  in  4*DIGITS  one nibble per digit; nibble k = value[4k+3:4k]; digit 0 is least significant.
REQ-008 dp_in  in  DIGITS  per-digit decimal point request, 1 = lit.
REQ-009 hex_mode  in  1  0 = decimal, 1 = hexadecimal glyphs.
REQ-010 lz_blank  in  1  1 = leading-zero blanking enabled.
REQ-011 seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
REQ-012 dp_n  out  1  decimal point, active-low.
REQ-013 an  out  DIGITS  digit enables, active-low, at most one bit low.
REQ-014 frame_done  out  1  one-cycle pulse at each scan wrap to digit 0.

Function
REQ-015 Glyphs for 0-9 SHALL be: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
REQ-016 hex_mode=1 glyphs for A-F SHALL be: 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-017 hex_mode=0 with a nibble of 10-15 SHALL produce seg=1111111 for that digit.
REQ-018 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; the terminal count SHALL be SCAN_DIV-1.
REQ-019 On each terminal count, the digit index SHALL advance by 1, wrapping DIGITS-1 to 0.
REQ-020 seg, dp_n and an SHALL be registered and change on the same edge the index advances.
REQ-021 At the index wrap to 0, frame_done SHALL be 1 for exactly that cycle; period is DIGITS*SCAN_DIV cycles.
REQ-022 A load SHALL capture into the shadow register and set pending.
REQ-023 Shadow contents SHALL transfer to the active register only at the index wrap to 0, so no torn frame is displayed.
REQ-024 Transfer SHALL clear pending, and digit 0 of the new frame SHALL already show the new data.
REQ-025 Multiple loads within one frame: the last load SHALL win.
REQ-026 A load coincident with the wrap SHALL be displayed in the following frame.
REQ-027 Leading-zero blanking: with lz_blank=1, the run of zero nibbles from digit DIGITS-1 downward SHALL drive seg=1111111.
REQ-028 Digit 0 SHALL never be blanked; value 0 shows a single "0".
REQ-029 For a blanked digit, an SHALL still be asserted and dp_n SHALL still follow dp_in.
REQ-030 dp_n SHALL equal the inverse of the active dp bit of the current digit.

Reset
REQ-031 On rst, the prescaler SHALL go to 0 and the index to DIGITS-1.
REQ-032 On rst, the active and shadow registers and pending SHALL clear to 0.
REQ-033 On rst, outputs SHALL be: an all 1, seg=1111111, dp_n=1, frame_done=0.
REQ-034 rst SHALL take priority over load and over the terminal count in the same cycle.
REQ-035 After release, the first terminal count SHALL wrap the index to 0 with a frame_done pulse; this is the first lit digit.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-036 Reset, then load value=16'h1234, hex_mode=0 -> next frame shows an=1110 seg=1001100, an=1101 seg=0000110, an=1011 seg=0010010, an=0111 seg=1001111.
REQ-037 Load 16'hABCD, hex_mode=1 -> digits 0..3 show 1000010, 0110001, 1100000, 0001000; with hex_mode=0, all four show 1111111.
REQ-038 lz_blank=1, value=16'h0070 -> digits 3 and 2 show 1111111, digit 1 shows 0001111, digit 0 shows 0000001; value=0 -> only digit 0 shows 0000001.
REQ-039 Load 16'h1111 mid-frame, then 16'h2222 two cycles later -> rest of the current frame shows the old data; the next frame shows all 0010010.
REQ-040 frame_done is high exactly one cycle in every 16; assert rst mid-slot -> next cycle an=1111, seg=1111111, frame_done=0, and the first frame_done comes 4 cycles after release.

Source files
------------

// File: rtl/multi_digit_display_driver.sv
// rtl/multi_digit_display_driver.sv - time-multiplexed 7-segment display driver with frame-synchronous update
module multi_digit_display_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                hex_mode,
  input  logic                lz_blank,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shd_value_q, shd_value_d, act_value_q, act_value_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic                shd_hex_q, shd_hex_d, act_hex_q, act_hex_d;
  logic                shd_lz_q, shd_lz_d, act_lz_q, act_lz_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                tc, wrap, blank, dp_bit;
  logic [3:0]          nib;

  // Segment pattern {a..g}, active-low; non-decimal nibbles go dark unless hex is selected.
  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = hex ? 7'b0001000 : 7'b1111111;
      4'hB: g = hex ? 7'b1100000 : 7'b1111111;
      4'hC: g = hex ? 7'b0110001 : 7'b1111111;
      4'hD: g = hex ? 7'b1000010 : 7'b1111111;
      4'hE: g = hex ? 7'b0110000 : 7'b1111111;
      default: g = hex ? 7'b0111000 : 7'b1111111;
    endcase
    return g;
  endfunction

  // Scan timing: prescaler terminal count steps the digit index; the step out of the top digit is a frame wrap.
  always_comb begin
    tc      = (presc_q == PW'(SCAN_DIV - 1));
    wrap    = tc && (idx_q == IW'(DIGITS - 1));
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (tc) begin
      presc_d = '0;
      idx_d   = wrap ? '0 : idx_q + 1'b1;
    end
    frame_done_d = wrap;
  end

  // Double buffering: loads land in the shadow; the active copy only changes at a frame wrap.
  // The transfer uses the shadow as it was before this cycle, so a load on the wrap waits a frame.
  always_comb begin
    shd_value_d = shd_value_q;
    shd_dp_d    = shd_dp_q;
    shd_hex_d   = shd_hex_q;
    shd_lz_d    = shd_lz_q;
    pending_d   = pending_q;
    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_hex_d   = act_hex_q;
    act_lz_d    = act_lz_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (pending_q) begin
        act_value_d = shd_value_q;
        act_dp_d    = shd_dp_q;
        act_hex_d   = shd_hex_q;
        act_lz_d    = shd_lz_q;
      end
    end
    if (load) begin
      shd_value_d = value;
      shd_dp_d    = dp_in;
      shd_hex_d   = hex_mode;
      shd_lz_d    = lz_blank;
      pending_d   = 1'b1;
    end
  end

  // Decode the digit about to be shown from the next active data, so the new frame's digit 0 is already fresh.
  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    blank  = act_lz_d && (idx_d != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if (j == int'(idx_d)) begin
        nib    = act_value_d[j*4 +: 4];
        dp_bit = act_dp_d[j];
      end
      if ((j >= int'(idx_d)) && (act_value_d[j*4 +: 4] != 4'h0)) begin
        blank = 1'b0;
      end
    end
    seg_d  = seg_q;
    dp_n_d = dp_n_q;
    an_d   = an_q;
    if (tc) begin
      seg_d  = blank ? 7'b1111111 : glyph(nib, act_hex_d);
      dp_n_d = ~dp_bit;
      for (int j = 0; j < DIGITS; j++) begin
        an_d[j] = (j != int'(idx_d));
      end
    end
  end

  // State registers; reset parks the index on the top digit so the first terminal count starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= IW'(DIGITS - 1);
      shd_value_q  <= '0;
      shd_dp_q     <= '0;
      shd_hex_q    <= 1'b0;
      shd_lz_q     <= 1'b0;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_hex_q    <= 1'b0;
      act_lz_q     <= 1'b0;
      pending_q    <= 1'b0;
      seg_q        <= 7'b1111111;
      dp_n_q       <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shd_value_q  <= shd_value_d;
      shd_dp_q     <= shd_dp_d;
      shd_hex_q    <= shd_hex_d;
      shd_lz_q     <= shd_lz_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_hex_q    <= act_hex_d;
      act_lz_q     <= act_lz_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
